// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin read-port arbiter with bounded lock bursts and tagged response return
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 8
`endif

module mem_rd_arbiter #(
    parameter int N_REQ    = 4,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8,
    parameter int AW       = `MEM_ADDR_WIDTH,
    parameter int DW       = `MEM_DATA_WIDTH
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    req_lock_i,
    input  logic [N_REQ*AW-1:0] req_addr_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [AW-1:0]       ram_addr_o,
    output logic                ram_rd_o,
    input  logic [DW-1:0]       ram_rdata_i,
    output logic [N_REQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]       rsp_data_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {FREE, LOCKED} state_t;

    state_t          state_q;
    logic [IW-1:0]   lock_id_q;
    logic [CW-1:0]   lock_cnt_q;
    logic [IW-1:0]   ptr_q;
    logic            excl_vld_q;
    logic [IW-1:0]   excl_id_q;

    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   nxt_ptr;
    logic            lock_hold;
    int              rr_j;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        rr_j      = 0;
        lock_hold = (state_q == LOCKED) && req_i[lock_id_q];
        if (!reset_i) begin
            if (lock_hold) begin
                gnt_any = 1'b1;
                gnt_idx = lock_id_q;
            end else begin
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    rr_j = int'(ptr_q) + i;
                    if (rr_j >= N_REQ) rr_j = rr_j - N_REQ;
                    if (req_i[rr_j] && !(excl_vld_q && int'(excl_id_q) == rr_j)) begin
                        gnt_any = 1'b1;
                        gnt_idx = IW'(rr_j);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (gnt_any) gnt_o[gnt_idx] = 1'b1;
    end

    assign ram_rd_o   = gnt_any;
    assign ram_addr_o = gnt_any ? req_addr_i[gnt_idx*AW +: AW] : '0;
    assign nxt_ptr    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= FREE;
            lock_id_q  <= '0;
            lock_cnt_q <= '0;
            ptr_q      <= '0;
            excl_vld_q <= 1'b0;
            excl_id_q  <= '0;
        end else begin
            excl_vld_q <= 1'b0;
            if (state_q == LOCKED && !req_i[lock_id_q]) begin
                state_q    <= FREE;
                lock_cnt_q <= '0;
            end
            if (gnt_any) begin
                if (lock_hold) begin
                    if (!req_lock_i[gnt_idx]) begin
                        state_q    <= FREE;
                        lock_cnt_q <= '0;
                        ptr_q      <= nxt_ptr;
                    end else if (int'(lock_cnt_q) + 1 >= LOCK_MAX) begin
                        // Burst exhausted: rotate and keep k out of the very next round.
                        state_q    <= FREE;
                        lock_cnt_q <= '0;
                        ptr_q      <= nxt_ptr;
                        excl_vld_q <= 1'b1;
                        excl_id_q  <= gnt_idx;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end else begin
                    ptr_q <= nxt_ptr;
                    if (req_lock_i[gnt_idx]) begin
                        if (LOCK_MAX <= 1) begin
                            excl_vld_q <= 1'b1;
                            excl_id_q  <= gnt_idx;
                        end else begin
                            state_q    <= LOCKED;
                            lock_id_q  <= gnt_idx;
                            lock_cnt_q <= CW'(1);
                        end
                    end
                end
            end
        end
    end

    logic [N_REQ-1:0] tag_q [RD_LAT];
    logic [N_REQ-1:0] tag_d [RD_LAT];
    logic [DW-1:0]    rsp_data_q;

    always_comb begin
        tag_d[0] = gnt_o;
        for (int s = 1; s < RD_LAT; s++) tag_d[s] = tag_q[s-1];
    end

    // Data is latched on the edge that moves its tag into the last stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < RD_LAT; s++) tag_q[s] <= '0;
            rsp_data_q <= '0;
        end else begin
            for (int s = 0; s < RD_LAT; s++) tag_q[s] <= tag_d[s];
            if (|tag_d[RD_LAT-1]) rsp_data_q <= ram_rdata_i;
        end
    end

    assign rsp_valid_o = tag_q[RD_LAT-1];
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_mem_rd_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_lock;
    logic [63:0] req_addr;

    logic [3:0]  gnt_a, gnt_b, rsp_valid_a, rsp_valid_b;
    logic [15:0] ram_addr_a, ram_addr_b, b_a1, b_a2;
    logic        ram_rd_a, ram_rd_b;
    logic [7:0]  rdata_a, rdata_b, rsp_data_a, rsp_data_b;

    logic [7:0]  mem [256];

    always #5 clk = ~clk;

    mem_rd_arbiter #(.N_REQ(4), .RD_LAT(1), .LOCK_MAX(LOCK_MAX), .AW(16), .DW(8)) dut_a (
        .clk_i(clk), .reset_i(rst), .req_i(req), .req_lock_i(req_lock), .req_addr_i(req_addr),
        .gnt_o(gnt_a), .ram_addr_o(ram_addr_a), .ram_rd_o(ram_rd_a), .ram_rdata_i(rdata_a),
        .rsp_valid_o(rsp_valid_a), .rsp_data_o(rsp_data_a));

    mem_rd_arbiter #(.N_REQ(4), .RD_LAT(3), .LOCK_MAX(LOCK_MAX), .AW(16), .DW(8)) dut_b (
        .clk_i(clk), .reset_i(rst), .req_i(req), .req_lock_i(req_lock), .req_addr_i(req_addr),
        .gnt_o(gnt_b), .ram_addr_o(ram_addr_b), .ram_rd_o(ram_rd_b), .ram_rdata_i(rdata_b),
        .rsp_valid_o(rsp_valid_b), .rsp_data_o(rsp_data_b));

    // RAM models: latency 1 presents data in the grant cycle, latency 3 two cycles later.
    assign rdata_a = mem[ram_addr_a[7:0]];
    always @(posedge clk) begin
        b_a1 <= ram_addr_b;
        b_a2 <= b_a1;
    end
    assign rdata_b = mem[b_a2[7:0]];

    int n_pass = 0, n_tot = 0;
    int cyc = 0;
    int hid [1024];
    int hdat [1024];
    int m_lock = -1, m_cnt = 0, m_ptr = 0, m_excl = -1, m_last_g = -1;
    bit prev_rst = 1'b1;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [3:0]  lk;
        logic [63:0] ad;
        logic [3:0]  eg;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    function automatic logic [63:0] ad4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] l,
                                input logic [63:0] a, input logic [3:0] e);
        vec_t v;
        v.rst = r; v.rq = q; v.lk = l; v.ad = a; v.eg = e;
        return v;
    endfunction

    // One cycle: inputs already driven; check at negedge, then advance the model past the edge.
    task automatic step(input logic [3:0] eg, input bit use_eg);
        int g, idx, was_lock, nexcl;
        logic [3:0]  eoh;
        logic [15:0] ea;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (m_lock >= 0 && req[m_lock]) g = m_lock;
            else for (int i = 0; i < 4; i++) begin
                int j;
                j = (m_ptr + i) % 4;
                if (g < 0 && req[j] && j != m_excl) g = j;
            end
        end
        eoh = 4'b0;
        ea  = 16'h0;
        if (g >= 0) begin
            eoh[g] = 1'b1;
            ea = req_addr[16*g +: 16];
        end
        chk("gnt_a", gnt_a, eoh);
        chk("gnt_b", gnt_b, eoh);
        chk("ram_rd_a", ram_rd_a, g >= 0);
        chk("ram_rd_b", ram_rd_b, g >= 0);
        chk("ram_addr_a", ram_addr_a, ea);
        chk("ram_addr_b", ram_addr_b, ea);
        if (use_eg) chk("table_gnt", gnt_a, eg);

        idx = cyc - 1;
        eoh = 4'b0;
        if (idx >= 0 && hid[idx] >= 0) eoh[hid[idx]] = 1'b1;
        chk("rsp_valid_a", rsp_valid_a, eoh);
        if (eoh != 0) chk("rsp_data_a", rsp_data_a, hdat[idx]);
        idx = cyc - 3;
        eoh = 4'b0;
        if (idx >= 0 && hid[idx] >= 0) eoh[hid[idx]] = 1'b1;
        chk("rsp_valid_b", rsp_valid_b, eoh);
        if (eoh != 0) chk("rsp_data_b", rsp_data_b, hdat[idx]);
        if (prev_rst) begin
            chk("rst_data_a", rsp_data_a, 0);
            chk("rst_data_b", rsp_data_b, 0);
        end

        hid[cyc]  = g;
        hdat[cyc] = mem[ea[7:0]];
        if (rst) for (int k = cyc - 2; k < cyc; k++) if (k >= 0) hid[k] = -1;

        if (rst) begin
            m_lock = -1; m_cnt = 0; m_ptr = 0; m_excl = -1;
        end else begin
            was_lock = (m_lock >= 0 && req[m_lock]) ? m_lock : -1;
            nexcl = -1;
            if (m_lock >= 0 && !req[m_lock]) begin m_lock = -1; m_cnt = 0; end
            if (g >= 0) begin
                if (g == was_lock) begin
                    if (!req_lock[g]) begin
                        m_lock = -1; m_cnt = 0; m_ptr = (g + 1) % 4;
                    end else if (m_cnt + 1 >= LOCK_MAX) begin
                        m_lock = -1; m_cnt = 0; m_ptr = (g + 1) % 4; nexcl = g;
                    end else m_cnt++;
                end else begin
                    m_ptr = (g + 1) % 4;
                    if (req_lock[g]) begin m_lock = g; m_cnt = 1; end
                end
            end
            m_excl = nexcl;
        end
        prev_rst = rst;
        m_last_g = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] l, input logic [63:0] a);
        rst = r; req = q; req_lock = l; req_addr = a;
    endtask

    logic [3:0]  pend;
    logic [15:0] paddr [4];
    int pulses;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h85;
        mem[8'h20] = 8'h81; mem[8'h21] = 8'h82; mem[8'h22] = 8'h03;
        for (int i = 0; i < 1024; i++) begin hid[i] = -1; hdat[i] = 0; end
        drive(1'b1, 4'b0, 4'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;

        vt.push_back(mk(1, 4'b0000, 4'b0000, 64'h0, 4'b0000));
        vt.push_back(mk(0, 4'b0100, 4'b0000, ad4(0, 0, 'h10, 0), 4'b0100));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 64'h0, 4'b0000));
        vt.push_back(mk(0, 4'b1010, 4'b0000, ad4(0, 'h31, 0, 'h33), 4'b1000));
        vt.push_back(mk(0, 4'b0010, 4'b0000, ad4(0, 'h31, 0, 0), 4'b0010));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 64'h0, 4'b0000));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 64'h0, 4'b0000));
        vt.push_back(mk(0, 4'b1111, 4'b0000, ad4('h40, 'h41, 'h42, 'h43), 4'b0001));
        vt.push_back(mk(0, 4'b1111, 4'b0000, ad4('h44, 'h45, 'h46, 'h47), 4'b0010));
        vt.push_back(mk(0, 4'b1111, 4'b0000, ad4('h48, 'h49, 'h4a, 'h4b), 4'b0100));
        vt.push_back(mk(0, 4'b1111, 4'b0000, ad4('h4c, 'h4d, 'h4e, 'h4f), 4'b1000));
        vt.push_back(mk(0, 4'b1111, 4'b0000, ad4('h50, 'h51, 'h52, 'h53), 4'b0001));
        vt.push_back(mk(0, 4'b0011, 4'b0010, ad4('h58, 'h20, 0, 0), 4'b0010));
        vt.push_back(mk(0, 4'b0011, 4'b0010, ad4('h58, 'h21, 0, 0), 4'b0010));
        vt.push_back(mk(0, 4'b0011, 4'b0000, ad4('h58, 'h22, 0, 0), 4'b0010));
        vt.push_back(mk(0, 4'b0001, 4'b0000, ad4('h58, 0, 0, 0), 4'b0001));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 64'h0, 4'b0000));
        vt.push_back(mk(1, 4'b0000, 4'b0000, 64'h0, 4'b0000));
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(0, 4'b1001, 4'b0001, ad4('h60 + i, 0, 0, 'h63), 4'b0001));
        vt.push_back(mk(0, 4'b1001, 4'b0001, ad4('h64, 0, 0, 'h63), 4'b1000));
        vt.push_back(mk(0, 4'b0001, 4'b0001, ad4('h64, 0, 0, 0), 4'b0001));
        vt.push_back(mk(0, 4'b0000, 4'b0000, 64'h0, 4'b0000));

        foreach (vt[k]) begin
            drive(vt[k].rst, vt[k].rq, vt[k].lk, vt[k].ad);
            step(vt[k].eg, 1'b1);
        end

        // Reset while two RD_LAT=3 reads are in flight.
        drive(1, 4'b0000, 4'b0000, 64'h0);              step(4'b0000, 1'b1);
        drive(0, 4'b0011, 4'b0000, ad4('h70, 'h71, 0, 0)); step(4'b0001, 1'b1);
        drive(0, 4'b0010, 4'b0000, ad4(0, 'h71, 0, 0));    step(4'b0010, 1'b1);
        drive(1, 4'b0000, 4'b0000, 64'h0);
        pulses = 0;
        step(4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pulses += (rsp_valid_b != 0);
            drive(0, 4'b0000, 4'b0000, 64'h0);
            step(4'b0000, 1'b1);
        end
        chk("midflight_pulses", pulses, 0);
        chk("midflight_data_b", rsp_data_b, 0);
        drive(0, 4'b1111, 4'b0000, ad4('h01, 'h02, 'h03, 'h04)); step(4'b0001, 1'b1);

        pend = 4'b0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 16'($urandom_range(0, 255));
                end
            req_addr = {paddr[3], paddr[2], paddr[1], paddr[0]};
            req = pend;
            for (int i = 0; i < 4; i++) req_lock[i] = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 60) == 0);
            step(4'b0000, 1'b0);
            if (m_last_g >= 0) pend[m_last_g] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
